// File: rtl/rvfi_check_pkg.sv
// Shared types for the RVFI trace checker: error codes, FSM states and the
// lowest-code-wins priority helper.
package rvfi_check_pkg;

    localparam int XLEN = 32;

    typedef enum logic [3:0] {
        ERR_NONE       = 4'd0,
        ERR_ORDER      = 4'd1,
        ERR_PC_CONT    = 4'd2,
        ERR_X0         = 4'd3,
        ERR_PC_ALIGN   = 4'd4,
        ERR_MEM_ALIGN  = 4'd5,
        ERR_MEM_BOTH   = 4'd6,
        ERR_SHADOW     = 4'd7,
        ERR_AFTER_HALT = 4'd8
    } err_e;

    typedef enum logic [1:0] {
        WAIT_FIRST = 2'd0,
        RUN        = 2'd1,
        HALTED     = 2'd2,
        ERROR      = 2'd3
    } state_e;

    // Bit i of fails set means check code i failed; the lowest set code is reported.
    function automatic err_e first_err(input logic [8:1] fails);
        err_e e;
        e = ERR_NONE;
        for (int i = 8; i >= 1; i--) begin
            if (fails[i]) e = err_e'(4'(i));
        end
        return e;
    endfunction

endpackage

// File: rtl/rvfi_trace_checker_if.sv
// RVFI retirement trace bundle, single retire slot, XLEN=32.
// Handshake: rvfi_valid is a one-cycle strobe per retirement with no ready;
// the checker accepts every valid cycle, so all fields are meaningful only while rvfi_valid=1.
interface rvfi_trace_checker_if;
    import rvfi_check_pkg::*;

    logic            rvfi_valid;
    logic [63:0]     rvfi_order;
    logic [XLEN-1:0] rvfi_insn;
    logic            rvfi_trap;
    logic            rvfi_halt;
    logic [4:0]      rvfi_rs1_addr;
    logic [4:0]      rvfi_rs2_addr;
    logic [XLEN-1:0] rvfi_rs1_rdata;
    logic [XLEN-1:0] rvfi_rs2_rdata;
    logic [4:0]      rvfi_rd_addr;
    logic [XLEN-1:0] rvfi_rd_wdata;
    logic [XLEN-1:0] rvfi_pc_rdata;
    logic [XLEN-1:0] rvfi_pc_wdata;
    logic [XLEN-1:0] rvfi_mem_addr;
    logic [3:0]      rvfi_mem_rmask;
    logic [3:0]      rvfi_mem_wmask;

    modport master (
        output rvfi_valid, rvfi_order, rvfi_insn, rvfi_trap, rvfi_halt,
               rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rs1_rdata, rvfi_rs2_rdata,
               rvfi_rd_addr, rvfi_rd_wdata, rvfi_pc_rdata, rvfi_pc_wdata,
               rvfi_mem_addr, rvfi_mem_rmask, rvfi_mem_wmask
    );

    modport slave (
        input rvfi_valid, rvfi_order, rvfi_insn, rvfi_trap, rvfi_halt,
              rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rs1_rdata, rvfi_rs2_rdata,
              rvfi_rd_addr, rvfi_rd_wdata, rvfi_pc_rdata, rvfi_pc_wdata,
              rvfi_mem_addr, rvfi_mem_rmask, rvfi_mem_wmask
    );

endinterface

// File: rtl/rvfi_shadow_rf.sv
// Shadow copy of x1..x31 with per-register known bits; x0 always reads known zero.
// Data storage is not reset: the known bits alone decide whether a read is trusted.
module rvfi_shadow_rf
    import rvfi_check_pkg::*;
(
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic [4:0]      i_rs1_addr,
    output logic [XLEN-1:0] o_rs1_data,
    output logic            o_rs1_known,
    input  logic [4:0]      i_rs2_addr,
    output logic [XLEN-1:0] o_rs2_data,
    output logic            o_rs2_known,
    input  logic            i_we,
    input  logic [4:0]      i_wa,
    input  logic [XLEN-1:0] i_wd
);

    logic [XLEN-1:0] r_data [32];
    logic [31:0]     r_known;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_known <= '0;
        end else if (i_we && (i_wa != 5'd0)) begin
            r_known[i_wa] <= 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_we && (i_wa != 5'd0)) begin
            r_data[i_wa] <= i_wd;
        end
    end

    assign o_rs1_known = (i_rs1_addr == 5'd0) ? 1'b1 : r_known[i_rs1_addr];
    assign o_rs1_data  = (i_rs1_addr == 5'd0) ? '0   : r_data[i_rs1_addr];
    assign o_rs2_known = (i_rs2_addr == 5'd0) ? 1'b1 : r_known[i_rs2_addr];
    assign o_rs2_data  = (i_rs2_addr == 5'd0) ? '0   : r_data[i_rs2_addr];

endmodule

// File: rtl/rvfi_trace_checker.sv
// RVFI retirement checker: counts retirements and latches the first violation.
// Define RVFI_SHADOW_RF_EN to add source-operand checking against a shadow register file.
module rvfi_trace_checker
    import rvfi_check_pkg::*;
#(
    parameter logic [31:0] MAX_RETIRED             = 32'hFFFF_FFFF,
    parameter logic [63:0] FIRST_ORDER             = 64'd0,
    parameter bit          ERR_ON_VALID_AFTER_HALT = 1'b1
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    rvfi_trace_checker_if.slave  rvfi,
    output logic [31:0]          o_retired,
    output logic                 o_err,
    output err_e                 o_err_code,
    output logic [63:0]          o_err_order,
    output logic [XLEN-1:0]      o_err_pc,
    output logic                 o_halted,
    output state_e               o_dbg_state
);

    state_e          r_state;
    logic [63:0]     r_exp_order;
    logic [XLEN-1:0] r_prev_pc;
    logic [31:0]     r_retired;
    logic            r_err;
    err_e            r_err_code;
    logic [63:0]     r_err_order;
    logic [XLEN-1:0] r_err_pc;
    logic            r_halted;

    logic [8:1] w_fail;
    err_e       w_err;
    logic       w_checking;
    logic       w_accept;
    logic       w_shadow_fail;

    assign w_checking = (r_state == WAIT_FIRST) || (r_state == RUN);
    assign w_accept   = rvfi.rvfi_valid && w_checking && (w_err == ERR_NONE);

`ifdef RVFI_SHADOW_RF_EN
    logic [XLEN-1:0] w_rs1_val;
    logic [XLEN-1:0] w_rs2_val;
    logic            w_rs1_known;
    logic            w_rs2_known;

    // Reads are combinational from the addresses, so the same-cycle write cannot mask a mismatch.
    rvfi_shadow_rf u_shadow (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_rs1_addr  (rvfi.rvfi_rs1_addr),
        .o_rs1_data  (w_rs1_val),
        .o_rs1_known (w_rs1_known),
        .i_rs2_addr  (rvfi.rvfi_rs2_addr),
        .o_rs2_data  (w_rs2_val),
        .o_rs2_known (w_rs2_known),
        .i_we        (w_accept && !rvfi.rvfi_trap),
        .i_wa        (rvfi.rvfi_rd_addr),
        .i_wd        (rvfi.rvfi_rd_wdata)
    );

    assign w_shadow_fail = (w_rs1_known && (w_rs1_val != rvfi.rvfi_rs1_rdata)) ||
                           (w_rs2_known && (w_rs2_val != rvfi.rvfi_rs2_rdata));
`else
    assign w_shadow_fail = 1'b0;
`endif

    always_comb begin
        w_fail    = '0;
        w_fail[1] = rvfi.rvfi_order != r_exp_order;
        w_fail[2] = (r_state == RUN) && (rvfi.rvfi_pc_rdata != r_prev_pc);
        w_fail[3] = (rvfi.rvfi_rd_addr == 5'd0) && (rvfi.rvfi_rd_wdata != '0);
        w_fail[4] = !rvfi.rvfi_trap && (rvfi.rvfi_pc_wdata[1:0] != 2'b00);
        w_fail[5] = ((rvfi.rvfi_mem_rmask | rvfi.rvfi_mem_wmask) != 4'd0) &&
                    (rvfi.rvfi_mem_addr[1:0] != 2'b00);
        w_fail[6] = (rvfi.rvfi_mem_rmask != 4'd0) && (rvfi.rvfi_mem_wmask != 4'd0);
        w_fail[7] = w_shadow_fail;
        w_err     = first_err(w_fail);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= WAIT_FIRST;
            r_exp_order <= FIRST_ORDER;
            r_prev_pc   <= '0;
            r_retired   <= '0;
            r_err       <= 1'b0;
            r_err_code  <= ERR_NONE;
            r_err_order <= '0;
            r_err_pc    <= '0;
            r_halted    <= 1'b0;
        end else begin
            case (r_state)
                WAIT_FIRST, RUN: begin
                    if (rvfi.rvfi_valid) begin
                        if (w_err != ERR_NONE) begin
                            r_state     <= ERROR;
                            r_err       <= 1'b1;
                            r_err_code  <= w_err;
                            r_err_order <= rvfi.rvfi_order;
                            r_err_pc    <= rvfi.rvfi_pc_rdata;
                        end else begin
                            r_state     <= rvfi.rvfi_halt ? HALTED : RUN;
                            r_exp_order <= r_exp_order + 64'd1;
                            r_prev_pc   <= rvfi.rvfi_pc_wdata;
                            r_halted    <= rvfi.rvfi_halt;
                            if (r_retired != MAX_RETIRED) r_retired <= r_retired + 32'd1;
                        end
                    end
                end
                HALTED: begin
                    if (rvfi.rvfi_valid && ERR_ON_VALID_AFTER_HALT) begin
                        r_state     <= ERROR;
                        r_err       <= 1'b1;
                        r_err_code  <= ERR_AFTER_HALT;
                        r_err_order <= rvfi.rvfi_order;
                        r_err_pc    <= rvfi.rvfi_pc_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_retired   = r_retired;
    assign o_err       = r_err;
    assign o_err_code  = r_err_code;
    assign o_err_order = r_err_order;
    assign o_err_pc    = r_err_pc;
    assign o_halted    = r_halted;
    assign o_dbg_state = r_state;

    // Informational fields and bits not covered by any check.
    logic w_unused;
    assign w_unused = ^{rvfi.rvfi_insn, rvfi.rvfi_rs1_addr, rvfi.rvfi_rs2_addr,
                        rvfi.rvfi_rs1_rdata, rvfi.rvfi_rs2_rdata, rvfi.rvfi_mem_addr[XLEN-1:2]};

endmodule

// File: tb/tb_rvfi_trace_checker.sv
// Directed bench for rvfi_trace_checker; shadow-register steps run when RVFI_SHADOW_RF_EN is defined.
module tb_rvfi_trace_checker;
    import rvfi_check_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [31:0] o_retired;
    logic        o_err;
    err_e        o_err_code;
    logic [63:0] o_err_order;
    logic [31:0] o_err_pc;
    logic        o_halted;
    state_e      o_dbg_state;

    int n_vec = 0;
    int n_mis = 0;

    rvfi_trace_checker_if rv ();

    rvfi_trace_checker dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .rvfi        (rv.slave),
        .o_retired   (o_retired),
        .o_err       (o_err),
        .o_err_code  (o_err_code),
        .o_err_order (o_err_order),
        .o_err_pc    (o_err_pc),
        .o_halted    (o_halted),
        .o_dbg_state (o_dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_fields();
        rv.rvfi_valid     = 1'b0;
        rv.rvfi_order     = '0;
        rv.rvfi_insn      = 32'h0000_0013;
        rv.rvfi_trap      = 1'b0;
        rv.rvfi_halt      = 1'b0;
        rv.rvfi_rs1_addr  = '0;
        rv.rvfi_rs2_addr  = '0;
        rv.rvfi_rs1_rdata = '0;
        rv.rvfi_rs2_rdata = '0;
        rv.rvfi_rd_addr   = '0;
        rv.rvfi_rd_wdata  = '0;
        rv.rvfi_pc_rdata  = '0;
        rv.rvfi_pc_wdata  = '0;
        rv.rvfi_mem_addr  = '0;
        rv.rvfi_mem_rmask = '0;
        rv.rvfi_mem_wmask = '0;
    endtask

    // Leaves time at posedge+1 with reset released.
    task automatic do_reset();
        rst_n = 1'b0;
        clear_fields();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // One retirement; extra fields are set by the caller beforehand and cleared afterwards.
    task automatic retire(input logic [63:0] ord, input logic [31:0] pc_r, input logic [31:0] pc_w);
        rv.rvfi_valid    = 1'b1;
        rv.rvfi_order    = ord;
        rv.rvfi_pc_rdata = pc_r;
        rv.rvfi_pc_wdata = pc_w;
        @(posedge clk);
        #1;
        clear_fields();
    endtask

    initial begin
        rst_n = 1'b0;
        clear_fields();
        #12;
        chk("rst_retired", o_retired, 0);
        chk("rst_err", o_err, 0);
        chk("rst_code", o_err_code, 0);
        chk("rst_err_order", o_err_order, 0);
        chk("rst_err_pc", o_err_pc, 0);
        chk("rst_halted", o_halted, 0);
        chk("rst_state", o_dbg_state, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Clean run of five, then halt, then a retirement after halt.
        retire(0, 32'h0, 32'h4);
        chk("t1_retired_1", o_retired, 1);
        retire(1, 32'h4, 32'h8);
        retire(2, 32'h8, 32'hC);
        retire(3, 32'hC, 32'h10);
        retire(4, 32'h10, 32'h14);
        chk("t1_retired_5", o_retired, 5);
        chk("t1_err", o_err, 0);
        chk("t1_state_run", o_dbg_state, 1);
        rv.rvfi_halt = 1'b1;
        retire(5, 32'h14, 32'h18);
        chk("halt_halted", o_halted, 1);
        chk("halt_retired", o_retired, 6);
        chk("halt_state", o_dbg_state, 2);
        retire(6, 32'h18, 32'h1C);
        chk("after_halt_err", o_err, 1);
        chk("after_halt_code", o_err_code, 8);
        chk("after_halt_order", o_err_order, 6);
        chk("after_halt_pc", o_err_pc, 32'h18);
        chk("after_halt_retired", o_retired, 6);
        chk("after_halt_state", o_dbg_state, 3);

        // Asynchronous reset between clock edges.
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_retired", o_retired, 0);
        chk("async_rst_err", o_err, 0);
        chk("async_rst_code", o_err_code, 0);
        chk("async_rst_order", o_err_order, 0);
        chk("async_rst_pc", o_err_pc, 0);
        chk("async_rst_halted", o_halted, 0);
        do_reset();

        // Order skip on the third retirement, then frozen outputs.
        retire(0, 32'h0, 32'h4);
        retire(1, 32'h4, 32'h8);
        retire(3, 32'h8, 32'hC);
        chk("order_err", o_err, 1);
        chk("order_code", o_err_code, 1);
        chk("order_err_order", o_err_order, 3);
        chk("order_err_pc", o_err_pc, 32'h8);
        chk("order_retired", o_retired, 2);
        retire(2, 32'h8, 32'hC);
        retire(7, 32'h40, 32'h41);
        chk("frozen_code", o_err_code, 1);
        chk("frozen_order", o_err_order, 3);
        chk("frozen_pc", o_err_pc, 32'h8);
        chk("frozen_retired", o_retired, 2);

        // pc continuity is not checked on the first retirement.
        do_reset();
        retire(0, 32'h8, 32'hC);
        chk("first_pc_err", o_err, 0);
        chk("first_pc_retired", o_retired, 1);
        retire(1, 32'hC, 32'h10);
        chk("second_pc_ok_retired", o_retired, 2);
        do_reset();
        retire(0, 32'h0, 32'h4);
        retire(1, 32'h8, 32'hC);
        chk("pc_cont_code", o_err_code, 2);
        chk("pc_cont_pc", o_err_pc, 32'h8);
        chk("pc_cont_order", o_err_order, 1);
        chk("pc_cont_retired", o_retired, 1);

        // x0 write and misaligned load together: lowest code wins.
        do_reset();
        rv.rvfi_rd_wdata  = 32'h1;
        rv.rvfi_mem_addr  = 32'h2;
        rv.rvfi_mem_rmask = 4'hF;
        retire(0, 32'h0, 32'h4);
        chk("x0_code", o_err_code, 3);
        chk("x0_retired", o_retired, 0);

        do_reset();
        rv.rvfi_rd_addr   = 5'd1;
        rv.rvfi_rd_wdata  = 32'h1;
        rv.rvfi_mem_addr  = 32'h2;
        rv.rvfi_mem_rmask = 4'hF;
        retire(0, 32'h0, 32'h4);
        chk("mem_align_code", o_err_code, 5);

        do_reset();
        rv.rvfi_mem_addr  = 32'h4;
        rv.rvfi_mem_rmask = 4'h3;
        rv.rvfi_mem_wmask = 4'hC;
        retire(0, 32'h0, 32'h4);
        chk("mem_both_code", o_err_code, 6);

        do_reset();
        retire(0, 32'h0, 32'h6);
        chk("pc_align_code", o_err_code, 4);

        // Trapped retirement may target any pc; continuity still follows it.
        do_reset();
        rv.rvfi_trap = 1'b1;
        retire(0, 32'h0, 32'h6);
        chk("trap_err", o_err, 0);
        retire(1, 32'h6, 32'h8);
        chk("trap_cont_err", o_err, 0);
        chk("trap_cont_retired", o_retired, 2);
        retire(2, 32'h9, 32'hC);
        chk("trap_cont_bad_code", o_err_code, 2);

`ifdef RVFI_SHADOW_RF_EN
        do_reset();
        rv.rvfi_rd_addr  = 5'd5;
        rv.rvfi_rd_wdata = 32'hDEAD_BEEF;
        retire(0, 32'h0, 32'h4);
        rv.rvfi_rs1_addr  = 5'd6;
        rv.rvfi_rs1_rdata = 32'h1234_5678;
        retire(1, 32'h4, 32'h8);
        chk("shadow_unknown_err", o_err, 0);
        rv.rvfi_rs1_addr  = 5'd5;
        rv.rvfi_rs1_rdata = 32'hDEAD_BEEF;
        retire(2, 32'h8, 32'hC);
        chk("shadow_match_err", o_err, 0);
        rv.rvfi_rs1_addr  = 5'd5;
        rv.rvfi_rs1_rdata = 32'h0;
        retire(3, 32'hC, 32'h10);
        chk("shadow_code", o_err_code, 7);
        chk("shadow_retired", o_retired, 3);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
